// File: rtl/pjon_tx_framer.sv
// pjon_tx_framer: collects one payload from the wrapper's send stream, then
// emits a PJON frame (ID, header, length, header CRC8, payload, CRC8) to PJDL.
// Stream buses are flattened as {tvalid, t.last, t.data[7:0]}; responses are tready.
module pjon_tx_framer #(
  parameter int unsigned MaxPayload = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] axis_tx_req_i,
  output logic       axis_tx_rsp_o,
  output logic [9:0] axis_tx_req_o,
  input  logic       axis_tx_rsp_i,
  input  logic [7:0] pjon_receiver_id_i,
  input  logic [7:0] pjon_header_i,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;

  typedef enum logic [2:0] {
    COLLECT, DROP, S_ID, S_HDR, S_LEN, S_HCRC, S_PAY, S_CRC
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, rd_ptr_q, crc_q, len_q, id_q, hdr_q;
  logic             overflow_q;
  logic [DataW-1:0] buf_q [MaxPayload];

  logic             in_valid, in_last, in_hs, out_hs;
  logic [DataW-1:0] in_data;
  logic             tready_c, tvalid_c, tlast_c;
  logic [DataW-1:0] tdata_c;
  logic             wr_en_c, frame_start_c, cnt_clr_c, crc_upd_c, rd_inc_c, overflow_c;

  // One PJON CRC8 byte step (reflected, polynomial 0x97).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data_in);
    logic [7:0] c;
    logic [7:0] b;
    logic       fb;
    c = crc_in;
    b = data_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[0];
      c  = c >> 1;
      if (fb) c = c ^ 8'h97;
      b  = b >> 1;
    end
    return c;
  endfunction

  assign in_valid = axis_tx_req_i[9];
  assign in_last  = axis_tx_req_i[8];
  assign in_data  = axis_tx_req_i[7:0];
  assign in_hs    = in_valid & tready_c;
  assign out_hs   = tvalid_c & axis_tx_rsp_i;

  assign axis_tx_rsp_o = tready_c;
  assign axis_tx_req_o = {tvalid_c, tlast_c, tdata_c};
  assign busy_o        = (state_q != COLLECT);
  assign overflow_o    = overflow_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  // Next-state, stream outputs and datapath strobes.
  always_comb begin
    state_d       = state_q;
    tready_c      = 1'b0;
    tvalid_c      = 1'b0;
    tlast_c       = 1'b0;
    tdata_c       = '0;
    wr_en_c       = 1'b0;
    frame_start_c = 1'b0;
    cnt_clr_c     = 1'b0;
    crc_upd_c     = 1'b0;
    rd_inc_c      = 1'b0;
    overflow_c    = 1'b0;
    case (state_q)
      COLLECT: begin
        tready_c = 1'b1;
        if (in_hs) begin
          if (cnt_q == 8'(MaxPayload)) begin
            // Buffer already full: this byte overflows the payload.
            if (in_last) begin
              overflow_c = 1'b1;
              cnt_clr_c  = 1'b1;
            end else begin
              state_d = DROP;
            end
          end else begin
            wr_en_c = 1'b1;
            if (in_last) begin
              frame_start_c = 1'b1;
              state_d       = S_ID;
            end
          end
        end
      end
      DROP: begin
        tready_c = 1'b1;
        if (in_hs && in_last) begin
          overflow_c = 1'b1;
          cnt_clr_c  = 1'b1;
          state_d    = COLLECT;
        end
      end
      S_ID: begin
        tvalid_c  = 1'b1;
        tdata_c   = id_q;
        crc_upd_c = out_hs;
        if (out_hs) state_d = S_HDR;
      end
      S_HDR: begin
        tvalid_c  = 1'b1;
        tdata_c   = hdr_q;
        crc_upd_c = out_hs;
        if (out_hs) state_d = S_LEN;
      end
      S_LEN: begin
        tvalid_c  = 1'b1;
        tdata_c   = len_q;
        crc_upd_c = out_hs;
        if (out_hs) state_d = S_HCRC;
      end
      S_HCRC: begin
        tvalid_c  = 1'b1;
        tdata_c   = crc_q;
        crc_upd_c = out_hs;
        if (out_hs) state_d = S_PAY;
      end
      S_PAY: begin
        tvalid_c  = 1'b1;
        tdata_c   = buf_q[AddrW'(rd_ptr_q)];
        crc_upd_c = out_hs;
        if (out_hs) begin
          rd_inc_c = 1'b1;
          if (rd_ptr_q == cnt_q - 8'd1) state_d = S_CRC;
        end
      end
      S_CRC: begin
        tvalid_c = 1'b1;
        tlast_c  = 1'b1;
        tdata_c  = crc_q;
        if (out_hs) begin
          cnt_clr_c = 1'b1;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Counters, latched frame fields, running CRC and overflow pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= 8'd0;
      rd_ptr_q   <= 8'd0;
      crc_q      <= 8'd0;
      len_q      <= 8'd0;
      id_q       <= 8'd0;
      hdr_q      <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_c;
      if (cnt_clr_c)    cnt_q <= 8'd0;
      else if (wr_en_c) cnt_q <= cnt_q + 8'd1;
      if (frame_start_c) begin
        id_q     <= pjon_receiver_id_i;
        hdr_q    <= pjon_header_i;
        len_q    <= cnt_q + 8'd6;
        crc_q    <= 8'd0;
        rd_ptr_q <= 8'd0;
      end else begin
        if (crc_upd_c) crc_q    <= crc8_step(crc_q, tdata_c);
        if (rd_inc_c)  rd_ptr_q <= rd_ptr_q + 8'd1;
      end
    end
  end

  // Payload buffer; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_c) buf_q[AddrW'(cnt_q)] <= in_data;
  end

endmodule
